// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths and fetch FSM state encodings
package fetch_stage_pkg;
  localparam int unsigned ADDR_SIZE  = 32;
  localparam int unsigned INSTR_SIZE = 32;
  typedef enum logic [1:0] {FS_REQ, FS_WAIT, FS_HOLD} fs_state_t;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing one imem request at a time and feeding decode through a 1-entry hold buffer
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_SIZE,
  parameter int unsigned       INSTR_W  = INSTR_SIZE,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic [ADDR_W-1:0]  PC_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               pipeline_out_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_target
);
  fs_state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, buf_pc;
  logic [INSTR_W-1:0] buf_instr;
  logic drop, drop_n, buf_valid, buf_load, buf_clr, out_load, out_from_buf, free;
  logic [ADDR_W-1:0] pc_inc;
  assign pc_inc = pc + ADDR_W'(PC_STEP);
  assign free = !pipeline_out_valid || !stall;
  assign imem_req_valid = (state == FS_REQ) && !reset;
  assign imem_req_addr = pc;
  // next-state, PC redirect and load strobes for the output and hold registers
  always_comb begin
    state_n = state;
    pc_n = pc;
    drop_n = drop;
    buf_load = 1'b0;
    buf_clr = 1'b0;
    out_load = 1'b0;
    out_from_buf = 1'b0;
    case (state)
      FS_REQ: begin
        state_n = imem_req_ready ? FS_WAIT : FS_REQ;
        pc_n = flush ? flush_target : pc;
        drop_n = flush && imem_req_ready;
      end
      FS_WAIT: begin
        if (imem_resp_valid) begin
          state_n = FS_REQ;
          drop_n = 1'b0;
          if (flush) pc_n = flush_target;
          else if (!drop) begin
            pc_n = pc_inc;
            out_load = free;
            buf_load = !free;
            state_n = free ? FS_REQ : FS_HOLD;
          end
        end else if (flush) begin
          drop_n = 1'b1;
          pc_n = flush_target;
        end
      end
      FS_HOLD: begin
        if (flush) begin
          buf_clr = 1'b1;
          pc_n = flush_target;
          state_n = FS_REQ;
        end else if (!stall) begin
          out_load = buf_valid;
          out_from_buf = 1'b1;
          buf_clr = 1'b1;
          state_n = FS_REQ;
        end
      end
      default: state_n = FS_REQ;
    endcase
  end
  // FSM, PC, stale-response tracking and hold buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FS_REQ;
      pc <= RESET_PC;
      drop <= 1'b0;
      buf_valid <= 1'b0;
      buf_pc <= '0;
      buf_instr <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      drop <= drop_n;
      if (buf_load) begin
        buf_valid <= 1'b1;
        buf_pc <= pc;
        buf_instr <= imem_resp_data;
      end else if (buf_clr) buf_valid <= 1'b0;
    end
  end
  // decode-facing registers: flush kills, stall holds, consumption without refill empties
  always_ff @(posedge clk) begin
    if (reset) begin
      pipeline_out_valid <= 1'b0;
      PC_out <= '0;
      instr_out <= '0;
    end else if (flush) pipeline_out_valid <= 1'b0;
    else if (out_load) begin
      pipeline_out_valid <= 1'b1;
      PC_out <= out_from_buf ? buf_pc : pc;
      instr_out <= out_from_buf ? buf_instr : imem_resp_data;
    end else if (!(stall && pipeline_out_valid)) pipeline_out_valid <= 1'b0;
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: per-cycle directed vectors with hand-computed expected fetch outputs
module tb_fetch_stage;
  logic clk = 1'b0, reset = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b0, imem_resp_valid = 1'b0, pipeline_out_valid;
  logic stall = 1'b0, flush = 1'b0;
  logic [31:0] imem_req_addr, imem_resp_data = '0, PC_out, instr_out, flush_target = '0;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic rst, st, fl, rdy, rv;
    logic [31:0] tgt, rd;
    logic e_rq;
    logic [31:0] e_addr;
    logic e_ov;
    logic [31:0] e_pc, e_in;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .PC_out(PC_out), .instr_out(instr_out), .pipeline_out_valid(pipeline_out_valid),
    .stall(stall), .flush(flush), .flush_target(flush_target)
  );
  function automatic vec_t v(input logic rst, st, fl, input logic [31:0] tgt, input logic rdy, rv,
                             input logic [31:0] rd, input logic e_rq, input logic [31:0] e_addr,
                             input logic e_ov, input logic [31:0] e_pc, e_in);
    vec_t r;
    r.rst = rst; r.st = st; r.fl = fl; r.tgt = tgt; r.rdy = rdy; r.rv = rv; r.rd = rd;
    r.e_rq = e_rq; r.e_addr = e_addr; r.e_ov = e_ov; r.e_pc = e_pc; r.e_in = e_in;
    return r;
  endfunction
  task automatic apply(input vec_t x, input string name);
    logic [97:0] got, exp;
    @(negedge clk);
    reset = x.rst; stall = x.st; flush = x.fl; flush_target = x.tgt;
    imem_req_ready = x.rdy; imem_resp_valid = x.rv; imem_resp_data = x.rd;
    #1;
    got = {imem_req_valid, imem_req_valid ? imem_req_addr : 32'h0, pipeline_out_valid,
           pipeline_out_valid ? PC_out : 32'h0, pipeline_out_valid ? instr_out : 32'h0};
    exp = {x.e_rq, x.e_rq ? x.e_addr : 32'h0, x.e_ov, x.e_ov ? x.e_pc : 32'h0, x.e_ov ? x.e_in : 32'h0};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got rq=%b addr=%h ov=%b pc=%h in=%h, want rq=%b addr=%h ov=%b pc=%h in=%h",
               name, got[97], got[96:65], got[64], got[63:32], got[31:0],
               exp[97], exp[96:65], exp[64], exp[63:32], exp[31:0]);
    end
  endtask
  initial begin
    tbl.push_back(v(1,0,0,0,   0,0,0,    0,0,    0,0,    0));
    tbl.push_back(v(0,0,0,0,   1,0,0,    1,0,    0,0,    0));
    tbl.push_back(v(0,0,0,0,   1,1,'h13, 0,0,    0,0,    0));
    tbl.push_back(v(0,0,0,0,   1,0,0,    1,4,    1,0,    'h13));
    tbl.push_back(v(0,0,0,0,   1,1,'h13, 0,0,    0,0,    0));
    tbl.push_back(v(0,1,0,0,   1,0,0,    1,8,    1,4,    'h13));
    tbl.push_back(v(0,1,0,0,   1,1,'h17, 0,0,    1,4,    'h13));
    tbl.push_back(v(0,1,0,0,   1,0,0,    0,0,    1,4,    'h13));
    tbl.push_back(v(0,1,0,0,   1,0,0,    0,0,    1,4,    'h13));
    tbl.push_back(v(0,1,0,0,   1,0,0,    0,0,    1,4,    'h13));
    tbl.push_back(v(0,0,0,0,   1,0,0,    0,0,    1,4,    'h13));
    tbl.push_back(v(0,0,0,0,   1,0,0,    1,'hC,  1,8,    'h17));
    tbl.push_back(v(0,0,0,0,   1,1,'h21, 0,0,    0,0,    0));
    tbl.push_back(v(0,1,0,0,   1,0,0,    1,'h10, 1,'hC,  'h21));
    tbl.push_back(v(0,0,1,'h100,1,0,0,   0,0,    1,'hC,  'h21));
    tbl.push_back(v(0,0,0,0,   1,1,'hDEAD,0,0,   0,0,    0));
    tbl.push_back(v(0,0,0,0,   1,0,0,    1,'h100,0,0,    0));
    tbl.push_back(v(0,0,0,0,   1,1,'h33, 0,0,    0,0,    0));
    tbl.push_back(v(0,0,1,'h200,1,0,0,   1,'h104,1,'h100,'h33));
    tbl.push_back(v(0,0,0,0,   1,1,'h44, 0,0,    0,0,    0));
    repeat (2) @(posedge clk);
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 10; i++) apply(v(0,0,0,0,0,0,0, 1,'h200,0,0,0), "req_not_ready");
    apply(v(0,0,0,0,1,0,0,      1,'h200,0,0,0),          "req_accept_200");
    apply(v(0,0,0,0,1,1,'h55,   0,0,0,0,0),              "resp_200");
    apply(v(0,1,0,0,1,0,0,      1,'h204,1,'h200,'h55),   "stall_req_204");
    apply(v(0,1,0,0,1,1,'h66,   0,0,1,'h200,'h55),       "stall_resp_to_hold");
    apply(v(1,1,0,0,1,0,0,      0,0,1,'h200,'h55),       "reset_in_hold");
    apply(v(1,0,0,0,1,0,0,      0,0,0,0,0),              "in_reset");
    apply(v(0,0,0,0,0,0,0,      1,0,0,0,0),              "after_reset_req0");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
